prog_event_counter: RTL

//  Parametrised successor to the team's 8-bit free-running counter. Counts

---
 rtl/prog_event_counter_if.sv | 29 ++
 rtl/prog_event_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/prog_event_counter_if.sv
// Control and status bundle for prog_event_counter: the controller drives the
// command/config side, the counter drives the count and status side.
interface prog_event_counter_if #(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
);
  logic               en;
  logic               clr;
  logic               start;
  logic               stop;
  logic               dir_down;
  logic               one_shot;
  logic [PRESC_W-1:0] presc_div;
  logic [CNT_W-1:0]   term_val;
  logic [CNT_W-1:0]   cnt;
  logic               tc;
  logic               done;
  logic               busy;

  modport master (
    output en, clr, start, stop, dir_down, one_shot, presc_div, term_val,
    input  cnt, tc, done, busy
  );

  modport slave (
    input  en, clr, start, stop, dir_down, one_shot, presc_div, term_val,
    output cnt, tc, done, busy
  );
endinterface

// File: rtl/prog_event_counter.sv
// Programmable up/down event counter with prescaler, auto-reload or one-shot,
// and a single-cycle terminal-count pulse.
module prog_event_counter #(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prog_event_counter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;
  logic               dir_q_r;
  logic               one_shot_q_r;
  logic [PRESC_W-1:0] div_q_r;
  logic [CNT_W-1:0]   term_q_r;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] presc_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               tc_r;
  logic               tc_nxt_s;
  logic               done_r;
  logic               busy_r;
  logic               tick_s;
  logic               at_end_s;
  logic               term_tick_s;
  logic [CNT_W-1:0]   start_val_s;
  logic [CNT_W-1:0]   load_val_s;

  assign tick_s      = (state_r == ST_RUN) && bus.en && (presc_r == div_q_r);
  assign at_end_s    = dir_q_r ? (cnt_r == {CNT_W{1'b0}}) : (cnt_r == term_q_r);
  assign term_tick_s = tick_s && at_end_s;
  // clr returns to the start value of the config already latched; start uses the new one
  assign start_val_s = dir_q_r ? term_q_r : {CNT_W{1'b0}};
  assign load_val_s  = bus.dir_down ? bus.term_val : {CNT_W{1'b0}};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic, priority clr > start > stop > tick
  always_comb begin
    state_nxt_s = state_r;
    if (bus.clr) begin
      state_nxt_s = ST_IDLE;
    end else if (bus.start) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.stop) begin
            state_nxt_s = ST_IDLE;
          end else if (term_tick_s && one_shot_q_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    cnt_nxt_s   = cnt_r;
    presc_nxt_s = presc_r;
    tc_nxt_s    = 1'b0;
    if (bus.clr) begin
      cnt_nxt_s   = start_val_s;
      presc_nxt_s = {PRESC_W{1'b0}};
    end else if (bus.start) begin
      cnt_nxt_s   = load_val_s;
      presc_nxt_s = {PRESC_W{1'b0}};
    end else if (bus.stop) begin
      cnt_nxt_s   = cnt_r;
    end else if ((state_r == ST_RUN) && bus.en) begin
      if (tick_s) begin
        presc_nxt_s = {PRESC_W{1'b0}};
        if (at_end_s) begin
          tc_nxt_s = 1'b1;
          if (one_shot_q_r) begin
            cnt_nxt_s = cnt_r;
          end else begin
            cnt_nxt_s = start_val_s;
          end
        end else if (dir_q_r) begin
          cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        presc_nxt_s = presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Datapath and status output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      presc_r <= {PRESC_W{1'b0}};
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      presc_r <= presc_nxt_s;
      tc_r    <= tc_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
      busy_r  <= (state_nxt_s == ST_RUN);
    end
  end

  // Configuration captured on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q_r      <= 1'b0;
      one_shot_q_r <= 1'b0;
      div_q_r      <= {PRESC_W{1'b0}};
      term_q_r     <= {CNT_W{1'b0}};
    end else if (bus.start && !bus.clr) begin
      dir_q_r      <= bus.dir_down;
      one_shot_q_r <= bus.one_shot;
      div_q_r      <= bus.presc_div;
      term_q_r     <= bus.term_val;
    end else begin
      dir_q_r      <= dir_q_r;
      one_shot_q_r <= one_shot_q_r;
      div_q_r      <= div_q_r;
      term_q_r     <= term_q_r;
    end
  end

  assign bus.cnt  = cnt_r;
  assign bus.tc   = tc_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;

endmodule
